// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: 8N1 UART receiver with mid-bit sampling and sticky status flags.
// Revision 1.0
`default_nettype none

module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       clear,
  output logic [7:0] out,
  output logic       valid,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_M1  = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s, rx_p;
  logic [11:0] tmr, tmr_n;
  logic [3:0]  cnt, cnt_n;
  logic [8:0]  sr, sr_n;
  logic [7:0]  out_n;
  logic        valid_n, framing_err_n, overrun_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_p        <= 1'b1;
      tmr         <= '0;
      cnt         <= '0;
      sr          <= 9'h1FF;
      out         <= 8'h00;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      rx_m        <= rx;
      rx_s        <= rx_m;
      rx_p        <= rx_s;
      tmr         <= tmr_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      out         <= out_n;
      valid       <= valid_n;
      framing_err <= framing_err_n;
      overrun     <= overrun_n;
    end
  end

  always_comb begin
    state_n       = state;
    tmr_n         = tmr;
    cnt_n         = cnt;
    sr_n          = sr;
    out_n         = out;
    // clear drops every flag; DONE below re-sets the ones it owns, so DONE wins.
    valid_n       = valid & ~clear;
    framing_err_n = framing_err & ~clear;
    overrun_n     = overrun & ~clear;

    case (state)
      IDLE: begin
        if (rx_p && !rx_s) begin
          state_n = START;
          tmr_n   = '0;
        end
      end
      START: begin
        if (tmr == HALF_M1) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            tmr_n   = '0;
            cnt_n   = '0;
          end
        end else begin
          tmr_n = tmr + 12'd1;
        end
      end
      DATA: begin
        if (tmr == BIT_M1) begin
          sr_n  = {rx_s, sr[8:1]};
          tmr_n = '0;
          cnt_n = cnt + 4'd1;
          // Eight data bits plus the stop bit make nine samples.
          if (cnt == 4'd8) state_n = DONE;
        end else begin
          tmr_n = tmr + 12'd1;
        end
      end
      DONE: begin
        out_n = sr[7:0];
        if (sr[8]) valid_n       = 1'b1;
        else       framing_err_n = 1'b1;
        if (valid) overrun_n     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer: directed self-checking bench for uart_rx_sequencer at 4 clocks per bit.
`default_nettype none

module tb_uart_rx_sequencer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] out;
  logic       valid, framing_err, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int waited;

  uart_rx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .clear(clear), .out(out),
    .valid(valid), .framing_err(framing_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, then the stop bit; returns just after the last bit period.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    waited = 0;
    while (busy && waited < 40) begin
      tick(1);
      waited++;
    end
    if (busy) check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_out",   32'(out), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fe",    32'(framing_err), 32'd0);
    check("rst_ovr",   32'(overrun), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    reset = 1'b0;
    tick(3);

    // Good frame 0x55; busy must fall exactly two cycles after the stop period ends.
    send_frame(8'h55, 1'b1);
    wait_idle("f55");
    check("f55_latency", 32'(waited), 32'd2);
    check("f55_out",   32'(out), 32'h55);
    check("f55_valid", 32'(valid), 32'd1);
    check("f55_fe",    32'(framing_err), 32'd0);
    check("f55_ovr",   32'(overrun), 32'd0);
    pulse_clear();
    check("f55_clr_valid", 32'(valid), 32'd0);

    // Framing error: stop bit 0.
    tick(2);
    send_frame(8'hA3, 1'b0);
    wait_idle("fA3");
    check("fA3_out",   32'(out), 32'hA3);
    check("fA3_fe",    32'(framing_err), 32'd1);
    check("fA3_valid", 32'(valid), 32'd0);
    pulse_clear();
    check("fA3_clr_fe", 32'(framing_err), 32'd0);

    // One-cycle glitch: arms START, then returns to IDLE with nothing changed.
    tick(2);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(2);
    check("gl_busy_start", 32'(busy), 32'd1);
    tick(2);
    check("gl_busy_end", 32'(busy), 32'd0);
    check("gl_valid",    32'(valid), 32'd0);
    check("gl_fe",       32'(framing_err), 32'd0);
    check("gl_out",      32'(out), 32'hA3);

    // Two frames without clear raise overrun.
    tick(2);
    send_frame(8'h12, 1'b1);
    wait_idle("f12");
    check("f12_ovr", 32'(overrun), 32'd0);
    tick(2);
    send_frame(8'h34, 1'b1);
    wait_idle("f34");
    check("f34_out",   32'(out), 32'h34);
    check("f34_valid", 32'(valid), 32'd1);
    check("f34_ovr",   32'(overrun), 32'd1);
    check("f34_fe",    32'(framing_err), 32'd0);
    pulse_clear();
    check("f34_clr_valid", 32'(valid), 32'd0);
    check("f34_clr_ovr",   32'(overrun), 32'd0);
    check("f34_clr_fe",    32'(framing_err), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF.
    tick(2);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + 2);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(2);
    check("rstmid_out",   32'(out), 32'h00);
    check("rstmid_busy",  32'(busy), 32'd0);
    check("rstmid_valid", 32'(valid), 32'd0);
    reset = 1'b0;
    tick(3);
    send_frame(8'h0F, 1'b1);
    wait_idle("f0F");
    check("f0F_out",   32'(out), 32'h0F);
    check("f0F_valid", 32'(valid), 32'd1);
    pulse_clear();
    check("f0F_clr_valid", 32'(valid), 32'd0);

    // clear held across the DONE cycle of 0x81: DONE sets valid, clear removes it a cycle later.
    tick(2);
    send_frame(8'h81, 1'b1);
    tick(1);
    check("f81_done_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    tick(1);
    check("f81_valid_done", 32'(valid), 32'd1);
    check("f81_out",        32'(out), 32'h81);
    check("f81_ovr",        32'(overrun), 32'd0);
    tick(1);
    check("f81_valid_next", 32'(valid), 32'd0);
    clear = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clk cycles per serial bit (25 MHz / 115200); legal range 4..4095.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 SHALL have port clear  input  1  acknowledge; clears valid, framing_err and overrun.
REQ-006 SHALL have port out  output  8  last received data byte.
REQ-007 SHALL have port valid  output  1  sticky; set when a byte completes with a good stop bit.
REQ-008 SHALL have port framing_err  output  1  sticky; set when the sampled stop bit is 0.
REQ-009 SHALL have port overrun  output  1  sticky; set when a byte completes while valid=1.
REQ-010 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s plus a registered copy (rx_p).
REQ-012 SHALL contain a 9-bit right-shift register sr: on each sample, sr <= {rx_s, sr[8:1]}; no other write except reset.
REQ-013 SHALL implement states IDLE, START, DATA, DONE with a bit-timer tmr (12 bits) and a sample counter cnt (4 bits).
REQ-014 IDLE: on falling edge (rx_p=1, rx_s=0) -> START, tmr<=0; a steady low line SHALL NOT start a frame.
REQ-015 START: when tmr = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; 1 -> IDLE (glitch, no flag change); 0 -> DATA, tmr<=0, cnt<=0.
REQ-016 DATA: when tmr = CLKS_PER_BIT - 1, shift sr, tmr<=0, cnt<=cnt+1; after the 9th shift (cnt reaches 9) -> DONE; otherwise tmr increments each cycle.
REQ-017 After 9 shifts sr[7:0] SHALL hold data bits 0..7 and sr[8] the stop bit.
REQ-018 DONE (one cycle): out<=sr[7:0] always; if sr[8]=1 set valid, else set framing_err; if valid was already 1, set overrun; -> IDLE.
REQ-019 Latency: valid SHALL rise on the cycle after the stop-bit sample, i.e. 1 cycle after the 9th shift.
REQ-020 clear SHALL deassert valid, framing_err and overrun the next cycle; clear in the same cycle as DONE: DONE-set flags win, clear still resets flags DONE does not set.
REQ-021 A falling edge during START/DATA/DONE SHALL be ignored; the next frame arms only in IDLE.
REQ-022 out SHALL change only in DONE or reset, including on framing error.

Reset
REQ-023 reset SHALL force state IDLE, tmr=0, cnt=0, sr=9'h1FF, synchronizer flops=1, out=8'h00, valid=0, framing_err=0, overrun=0, busy=0.
REQ-024 reset asserted mid-frame SHALL abandon the frame with no flag or out change other than the reset values; reset SHALL take priority over clear and DONE.

Verification (CLKS_PER_BIT=4)
REQ-025 Frame 0x55 with stop=1 -> out=8'h55, valid=1, framing_err=0, busy falls the cycle after DONE.
REQ-026 Frame 0xA3 with stop=0 -> out=8'hA3, framing_err=1, valid=0.
REQ-027 rx low pulse of 1 cycle in IDLE -> START then IDLE, valid/framing_err stay 0, out unchanged.
REQ-028 Two frames 0x12 then 0x34, no clear -> out=8'h34, valid=1, overrun=1; clear -> all three flags 0 next cycle.
REQ-029 reset asserted during data bit 4 of 0xFF -> out=8'h00, busy=0; following frame 0x0F -> out=8'h0F, valid=1.
REQ-030 clear held high on the DONE cycle of 0x81 -> valid=1 after that cycle, 0 the cycle after if clear is still high.
